// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings and arbiter FSM state type.
// Types and constants only; no timing or flow control of its own.
package alu_pkg;

   localparam int OP_W = 4;

   typedef logic [OP_W-1:0] alu_op_t;

   localparam alu_op_t OP_ADD   = 4'd0;
   localparam alu_op_t OP_SUB   = 4'd1;
   localparam alu_op_t OP_AND   = 4'd2;
   localparam alu_op_t OP_OR    = 4'd3;
   localparam alu_op_t OP_XOR   = 4'd4;
   localparam alu_op_t OP_NOT   = 4'd5;
   localparam alu_op_t OP_SHL   = 4'd6;
   localparam alu_op_t OP_SHR   = 4'd7;
   localparam alu_op_t OP_SRA   = 4'd8;
   localparam alu_op_t OP_ROL   = 4'd9;
   localparam alu_op_t OP_ROR   = 4'd10;
   localparam alu_op_t OP_MUL   = 4'd11;
   localparam alu_op_t OP_SLT   = 4'd12;
   localparam alu_op_t OP_SLTU  = 4'd13;
   localparam alu_op_t OP_PASSA = 4'd14;
   localparam alu_op_t OP_PASSB = 4'd15;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid bit at or above ptr, wrapping.
// Zero latency; no flow control, the caller decides when the pick is consumed.
module rr_pick #(
   parameter int NREQ  = 4,
   parameter int PTR_W = 2
) (
   input  logic [NREQ-1:0]  valid,
   input  logic [PTR_W-1:0] ptr,
   output logic [NREQ-1:0]  grant,
   output logic [PTR_W-1:0] grant_idx,
   output logic             any
);

   int idx;

   // Scan from farthest offset down so the nearest valid bit to ptr wins last.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      idx       = 0;
      for (int off = NREQ - 1; off >= 0; off--) begin
         idx = int'(ptr) + off;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         if (valid[idx]) begin
            grant      = '0;
            grant[idx] = 1'b1;
            grant_idx  = PTR_W'(idx);
            any        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_op_arbiter.sv
// Round-robin sharing of one ALU among NREQ valid/ready requesters.
// One op per LAT+3 cycles; req_ready only in IDLE, responses are one-cycle strobes.
module alu_op_arbiter
   import alu_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 16,
   parameter int LAT   = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*OP_W-1:0]  req_op,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic [NREQ-1:0]       rsp_valid,
   output logic [WIDTH-1:0]      rsp_data,
   output logic [OP_W-1:0]       alu_op,
   output logic [WIDTH-1:0]      alu_a,
   output logic [WIDTH-1:0]      alu_b,
   output logic                  alu_start,
   input  logic [WIDTH-1:0]      alu_result,
   output logic                  busy
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNT_LAST = (LAT > 0) ? LAT - 1 : 0;

   arb_state_t        state;
   logic [PTR_W-1:0]  rr_ptr;
   logic [PTR_W-1:0]  grant_idx;
   logic [3:0]        cnt;

   logic [NREQ-1:0]   win_oh;
   logic [PTR_W-1:0]  win_idx;
   logic              win_any;
   alu_op_t           sel_op;
   logic [WIDTH-1:0]  sel_a;
   logic [WIDTH-1:0]  sel_b;

   rr_pick #(
      .NREQ  (NREQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .valid     (req_valid),
      .ptr       (rr_ptr),
      .grant     (win_oh),
      .grant_idx (win_idx),
      .any       (win_any)
   );

   always_comb begin
      sel_op = '0;
      sel_a  = '0;
      sel_b  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_idx == PTR_W'(i)) begin
            sel_op = req_op[i*OP_W +: OP_W];
            sel_a  = req_a[i*WIDTH +: WIDTH];
            sel_b  = req_b[i*WIDTH +: WIDTH];
         end
      end
   end

   // Gated by rst_n so no handshake can appear to complete while held in reset.
   assign req_ready = ((state == IDLE) && rst_n) ? win_oh : '0;
   assign alu_start = (state == ISSUE);
   assign busy      = (state != IDLE);
   assign rsp_valid = (state == RESP) ? (NREQ'(1) << grant_idx) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         grant_idx <= '0;
         cnt       <= '0;
         alu_op    <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         rsp_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (win_any) begin
                  alu_op    <= sel_op;
                  alu_a     <= sel_a;
                  alu_b     <= sel_b;
                  grant_idx <= win_idx;
                  rr_ptr    <= (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               cnt <= '0;
               if (LAT == 0) begin
                  rsp_data <= alu_result;
                  state    <= RESP;
               end else begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (cnt == 4'(CNT_LAST)) begin
                  rsp_data <= alu_result;
                  state    <= RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_arbiter.sv
// Directed bench for alu_op_arbiter with LAT=1, LAT=4 and LAT=0 instances on shared inputs.
// Each ALU model returns a+b only in its result cycle and 16'hDEAD otherwise.
module tb_alu_op_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [15:0] req_op;
   logic [63:0] req_a;
   logic [63:0] req_b;

   logic [3:0]  ready1, rspv1, op1;
   logic [15:0] rspd1, a1, b1, res1;
   logic        start1, busy1;
   logic [3:0]  ready4, rspv4, op4;
   logic [15:0] rspd4, a4, b4, res4;
   logic        start4, busy4;
   logic [3:0]  ready0, rspv0, op0;
   logic [15:0] rspd0, a0, b0, res0;
   logic        start0, busy0;

   logic        d1;
   logic [3:0]  d4;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      d1 <= start1;
      d4 <= {d4[2:0], start4};
   end
   assign res1 = d1    ? a1 + b1 : 16'hDEAD;
   assign res4 = d4[3] ? a4 + b4 : 16'hDEAD;
   assign res0 = start0 ? a0 + b0 : 16'hDEAD;

   alu_op_arbiter #(.NREQ(4), .WIDTH(16), .LAT(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready1),
      .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rspv1),
      .rsp_data(rspd1), .alu_op(op1), .alu_a(a1), .alu_b(b1),
      .alu_start(start1), .alu_result(res1), .busy(busy1));

   alu_op_arbiter #(.NREQ(4), .WIDTH(16), .LAT(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready4),
      .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rspv4),
      .rsp_data(rspd4), .alu_op(op4), .alu_a(a4), .alu_b(b4),
      .alu_start(start4), .alu_result(res4), .busy(busy4));

   alu_op_arbiter #(.NREQ(4), .WIDTH(16), .LAT(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready0),
      .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rspv0),
      .rsp_data(rspd0), .alu_op(op0), .alu_a(a0), .alu_b(b0),
      .alu_start(start0), .alu_result(res0), .busy(busy0));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int          order [5] = '{0, 1, 2, 3, 0};
   logic [3:0]  op_t  [4] = '{4'h9, 4'hA, 4'hB, 4'hC};
   logic [15:0] sum_t [4] = '{16'h1011, 16'h2022, 16'h3033, 16'h4044};

   initial begin
      rst_n     = 1'b0;
      req_valid = 4'b1111;
      req_op    = {4'hC, 4'hB, 4'hA, 4'h3};
      req_a     = {16'h4000, 16'h3000, 16'h2000, 16'h0005};
      req_b     = {16'h0044, 16'h0033, 16'h0022, 16'h0007};
      step();
      step();

      // reset state with all requests valid
      check("rst_ready", 32'(ready1), 32'h0);
      check("rst_start", 32'(start1), 32'h0);
      check("rst_busy",  32'(busy1),  32'h0);
      check("rst_rspv",  32'(rspv1),  32'h0);
      check("rst_rspd",  32'(rspd1),  32'h0);
      check("rst_op",    32'(op1),    32'h0);
      check("rst_a",     32'(a1),     32'h0);
      check("rst_b",     32'(b1),     32'h0);

      // first accept after release: requester 0, then single-request flow
      rst_n = 1'b1;
      #1;
      check("first_ready", 32'(ready1), 32'h1);
      req_valid = 4'b0001;
      step();
      check("t1_start", 32'(start1), 32'h1);
      check("t1_op",    32'(op1),    32'h3);
      check("t1_a",     32'(a1),     32'h0005);
      check("t1_b",     32'(b1),     32'h0007);
      check("t1_busy",  32'(busy1),  32'h1);
      check("t1_ready", 32'(ready1), 32'h0);
      req_valid = 4'b0000;
      step();
      check("t2_start", 32'(start1), 32'h0);
      check("t2_busy",  32'(busy1),  32'h1);
      check("t2_rspv",  32'(rspv1),  32'h0);
      step();
      check("t3_rspv",  32'(rspv1),  32'h1);
      check("t3_rspd",  32'(rspd1),  32'h000C);
      check("t3_busy",  32'(busy1),  32'h1);
      step();
      check("t4_rspv",  32'(rspv1),  32'h0);
      check("t4_busy",  32'(busy1),  32'h0);
      check("t4_hold_op", 32'(op1),  32'h3);

      // all four valid from reset: order 0,1,2,3,0 with spacing 4
      req_op[3:0]  = 4'h9;
      req_a[15:0]  = 16'h1000;
      req_b[15:0]  = 16'h0011;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      req_valid = 4'b1111;
      #1;
      for (int i = 0; i < 5; i++) begin
         check("rr_ready", 32'(ready1), 32'(4'b0001 << order[i]));
         check("rr_idle",  32'(busy1),  32'h0);
         step();
         check("rr_op",    32'(op1),    32'(op_t[order[i]]));
         check("rr_busy_ready1", 32'(ready1), 32'h0);
         step();
         check("rr_busy_ready2", 32'(ready1), 32'h0);
         step();
         check("rr_rspv",  32'(rspv1),  32'(4'b0001 << order[i]));
         check("rr_rspd",  32'(rspd1),  32'(sum_t[order[i]]));
         check("rr_busy_ready3", 32'(ready1), 32'h0);
         step();
      end

      // wrap: serve req3, then req3 and req1 together -> req1 wins
      req_valid = 4'b1000;
      #1;
      check("wrap_r3", 32'(ready1), 32'h8);
      step();
      req_valid = 4'b1010;
      step();
      step();
      check("wrap_rsp3", 32'(rspv1), 32'h8);
      check("wrap_rspd3", 32'(rspd1), 32'h4044);
      step();
      check("wrap_r1", 32'(ready1), 32'h2);
      req_valid = 4'b0000;
      step();

      // LAT=4: accept req2, reset at T+3, no response, pointer back to 0
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      req_valid = 4'b0100;
      #1;
      check("l4_ready", 32'(ready4), 32'h4);
      step();
      check("l4_start", 32'(start4), 32'h1);
      check("l4_op",    32'(op4),    32'hB);
      req_valid = 4'b0000;
      step();
      step();
      check("l4_busy",  32'(busy4),  32'h1);
      rst_n = 1'b0;
      #1;
      check("ab_busy",  32'(busy4),  32'h0);
      check("ab_ready", 32'(ready4), 32'h0);
      check("ab_rspv",  32'(rspv4),  32'h0);
      check("ab_start", 32'(start4), 32'h0);
      check("ab_op",    32'(op4),    32'h0);
      check("ab_rspd",  32'(rspd4),  32'h0);
      req_valid = 4'b1111;
      #1;
      check("ab_ready_in_rst", 32'(ready4), 32'h0);
      for (int i = 0; i < 5; i++) begin
         step();
         check("ab_norsp", 32'(rspv4), 32'h0);
      end
      rst_n = 1'b1;
      #1;
      check("ab_ptr", 32'(ready4), 32'h1);

      // LAT=0: opcode sweep from requester 2
      req_valid = 4'b0000;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      req_valid = 4'b0100;
      for (int k = 0; k < 16; k++) begin
         req_op[11:8]  = 4'(k);
         req_a[47:32]  = 16'h1000 + 16'(k);
         req_b[47:32]  = 16'h0020;
         #1;
         check("sw_ready", 32'(ready0), 32'h4);
         step();
         check("sw_op",    32'(op0),    32'(k));
         check("sw_start", 32'(start0), 32'h1);
         check("sw_busy",  32'(busy0),  32'h1);
         step();
         check("sw_rspv",  32'(rspv0),  32'h4);
         check("sw_rspd",  32'(rspd0),  32'(16'h1020 + 16'(k)));
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_op_arbiter.md
Name: alu_op_arbiter

Overview:
Shares the single ALU datapath, including its 4-to-16 one-hot op decoder, among NREQ requesters. Each requester presents an opcode and two operands with a valid/ready handshake. The arbiter grants one requester at a time in round-robin order, drives and holds alu_op and the operands for the ALU latency, captures the result, and returns it to the granted requester.

Parameters:
NREQ, 4, number of requesters; legal range 2..16.
WIDTH, 16, operand and result width.
LAT, 1, cycles from the alu_start cycle to the cycle in which alu_result is valid; 0 means a combinational ALU; legal range 0..15.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  one-hot accept; all zero or one bit set
req_op  in  NREQ*4  packed opcodes; requester i uses bits [4i+3:4i]
req_a  in  NREQ*WIDTH  packed operand A
req_b  in  NREQ*WIDTH  packed operand B
rsp_valid  out  NREQ  one-hot single-cycle response strobe
rsp_data  out  WIDTH  result; valid while rsp_valid is nonzero
alu_op  out  4  opcode to the ALU decoder; registered
alu_a  out  WIDTH  registered operand A to the ALU
alu_b  out  WIDTH  registered operand B to the ALU
alu_start  out  1  single-cycle issue pulse
alu_result  in  WIDTH  ALU output
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE, rr_ptr=0.
  - alu_op=0, alu_a=0, alu_b=0, alu_start=0.
  - rsp_valid=0, rsp_data=0, busy=0.
  - req_ready=0 while rst_n is low.
- Reset mid-operation aborts the transaction. No rsp_valid is ever produced for it.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - req_ready is combinational: the one-hot winner among req_valid, searching upward from rr_ptr and wrapping modulo NREQ.
  - Handshake completes in the cycle where req_valid[i] and req_ready[i] are both high; call it cycle T.
  - At the end of T: latch the winner's op, a and b into alu_op/alu_a/alu_b; store the grant index; rr_ptr = (winner+1) mod NREQ; go to ISSUE.
  - If no req_valid bit is set, stay in IDLE with req_ready=0.
- ISSUE (cycle T+1):
  - alu_start=1; cnt=0.
  - If LAT==0, sample alu_result into rsp_data and go to RESP; otherwise go to WAIT.
- WAIT:
  - cnt increments each cycle.
  - In the cycle where cnt==LAT-1, i.e. cycle T+1+LAT, capture alu_result into rsp_data and go to RESP.
- RESP (cycle T+2+LAT):
  - rsp_valid[grant]=1 for exactly one cycle; go to IDLE.
  - req_ready is 0 in this cycle, so no back-to-back accept.
- Stability:
  - alu_op, alu_a and alu_b hold from ISSUE through the result-capture cycle.
  - They keep their values afterwards until the next accept; they are not cleared.
- Throughput: one operation per LAT+3 cycles.
- req_ready is 0 in every non-IDLE state.
- A requester may drop req_valid before being accepted with no side effect.
- All 16 opcodes pass through unmodified; the arbiter does not interpret them.
- Round-robin fairness: after requester k is served, k has the lowest priority. With all requesters valid, grant order from reset is 0,1,...,NREQ-1,0.
- Wrap: rr_ptr=NREQ-1 plus a grant to NREQ-1 gives rr_ptr=0.

Decomposition:
- Shared package alu_pkg:
  - OP_W=4.
  - alu_op_t typedef (4-bit).
  - Opcode localparams 0..15.
  - FSM state enum arb_state_t {IDLE, ISSUE, WAIT, RESP}.
- One sub-module rr_pick: combinational round-robin picker.
  - Inputs: valid[NREQ], ptr.
  - Outputs: one-hot grant[NREQ], grant index, any.

Test Plan:
- Reset with req_valid=4'b1111 held: all outputs 0 and req_ready=0 during reset. First accept after release is requester 0, op/a/b driven onto alu_op/alu_a/alu_b in cycle T+1.
- Single request: req0 op=4'd3, a=16'h0005, b=16'h0007, LAT=1, alu_result model = a+b. Expected: alu_start at T+1; rsp_valid=4'b0001 and rsp_data=16'h000C at T+3; busy high T+1..T+3.
- All four requesters held valid continuously: grant order is 0,1,2,3,0. Accept spacing is LAT+3 cycles. req_ready is never asserted outside IDLE.
- Wrap/fairness: after req3 is served, assert req3 and req1 together. req1 is granted first.
- Reset mid-WAIT (LAT=4, deassert rst_n at T+3): state returns to IDLE, no rsp_valid pulse, rr_ptr=0.
- LAT=0 build, opcode sweep 0..15 from req2: alu_op equals each opcode in its ISSUE cycle. rsp_valid=4'b0100 at T+2 with rsp_data captured from the same cycle's alu_result.
